// File: rtl/irq_request_latch.sv
// Front end of the 3-line priority encoder: synchronises raw requests, latches edges into
// pending bits, masks them and presents the highest-priority one over a valid/ready handshake.
module irq_request_latch #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          EDGE_MODE   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req_i,
    input  logic [2:0] mask_i,
    output logic [1:0] code_o,
    output logic       code_valid_o,
    input  logic       code_ready_i,
    output logic [2:0] pending_o,
    output logic       overflow_o,
    input  logic       clr_ovf_i
);

    typedef enum logic [0:0] {StIdle, StPresent} state_e;

    logic [SYNC_STAGES-1:0][2:0] sync_q;
    logic [2:0] sreq;
    logic [2:0] hreq_q;
    logic [2:0] rise;
    logic [2:0] pend_q;
    logic [2:0] pend_d;
    logic [2:0] clr;
    logic [2:0] elig;
    logic [1:0] enc;
    logic       ovf_q;
    logic       ovf_d;
    logic       accept;
    state_e     state_q;
    logic [1:0] code_q;
    logic       valid_q;

    // Stage 0 samples the raw line; the last stage is the metastability-safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            hreq_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_i};
            hreq_q <= sreq;
        end
    end

    assign sreq   = sync_q[SYNC_STAGES-1];
    assign rise   = sreq & ~hreq_q;
    assign accept = valid_q & code_ready_i;
    assign elig   = pend_q & mask_i;

    always_comb begin
        clr = 3'b000;
        if (EDGE_MODE && accept) begin
            case (code_q)
                2'b01:   clr = 3'b001;
                2'b10:   clr = 3'b010;
                2'b11:   clr = 3'b100;
                default: clr = 3'b000;
            endcase
        end
    end

    // A rise coinciding with the retiring accept re-arms the bit without flagging overflow.
    always_comb begin
        if (EDGE_MODE) begin
            pend_d = (pend_q & ~clr) | rise;
            ovf_d  = (|(rise & pend_q & ~clr)) | (ovf_q & ~clr_ovf_i);
        end else begin
            pend_d = sreq;
            ovf_d  = 1'b0;
        end
    end

    always_comb begin
        if (elig[2]) begin
            enc = 2'b11;
        end else if (elig[1]) begin
            enc = 2'b10;
        end else if (elig[0]) begin
            enc = 2'b01;
        end else begin
            enc = 2'b00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= 3'b000;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    // Once presented, the code is frozen until accepted; the return through idle gives the bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            code_q  <= 2'b00;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (elig != 3'b000) begin
                        code_q  <= enc;
                        valid_q <= 1'b1;
                        state_q <= StPresent;
                    end
                end
                StPresent: begin
                    if (code_ready_i) begin
                        code_q  <= 2'b00;
                        valid_q <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    code_q  <= 2'b00;
                    valid_q <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign code_o       = code_q;
    assign code_valid_o = valid_q;
    assign pending_o    = pend_q;
    assign overflow_o   = ovf_q;

endmodule
